pipe_stall_ctrl: RTL
====================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MEM_TMO, default 1023: number of consecutive MEM_WAIT cycles that triggers the error state.
REQ-002 Parameter CNT_W, default 32: width of the performance counter.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  run enable; low means the CPU is idle.
REQ-006 idex_memread_i  in  1  instruction in ID/EX is a load.
REQ-007 idex_rt_i  in  5  load destination register in ID/EX.
REQ-008 ifid_rs_i, ifid_rt_i  in  5 each  source registers of the instruction in IF/ID.
REQ-009 branch_taken_i  in  1  branch resolved taken in ID this cycle.
REQ-010 mem_req_i  in  1  MEM stage has an outstanding data-cache access.
REQ-011 mem_ack_i  in  1  data cache completes the access this cycle.
REQ-012 pc_hold_o  out  1  1 = PC keeps its value (PC write-inhibit polarity).
REQ-013 ifid_hold_o  out  1  IF/ID register holds.
REQ-014 ifid_flush_o  out  1  IF/ID register loads a NOP.
REQ-015 idex_bubble_o  out  1  ID/EX loads a NOP (control bits zero).
REQ-016 pipe_freeze_o  out  1  ID/EX, EX/MEM and MEM/WB all hold.
REQ-017 err_o  out  1  sticky memory-timeout error.
REQ-018 state_o  out  3  current FSM state encoding, for debug.

Function
REQ-019 FSM states: IDLE=0, RUN=1, MEM_WAIT=2, ERR=3; other encodings unused and map to IDLE.
REQ-020 IDLE: pc_hold_o=1, ifid_hold_o=1, pipe_freeze_o=1, all other outputs 0; start_i=1 -> RUN at next edge.
REQ-021 RUN, mem_req_i=1 and mem_ack_i=0: same-cycle pc_hold_o, ifid_hold_o, pipe_freeze_o = 1; flush and bubble forced 0; next state MEM_WAIT.
REQ-022 RUN, mem_req_i=1 and mem_ack_i=1: no stall; remain in RUN.
REQ-023 Load-use hazard = idex_memread_i & (idex_rt_i != 0) & (idex_rt_i == ifid_rs_i | idex_rt_i == ifid_rt_i).
REQ-024 RUN with no memory stall and a load-use hazard: pc_hold_o=1, ifid_hold_o=1, idex_bubble_o=1 for that single cycle; ifid_flush_o is forced 0 even if branch_taken_i=1.
REQ-025 RUN with no memory stall, no hazard and branch_taken_i=1: ifid_flush_o=1, pc_hold_o=0.
REQ-026 RUN with none of the above: all hold, flush and bubble outputs are 0.
REQ-027 Priority, highest first: memory stall, load-use hazard, branch flush.
REQ-028 MEM_WAIT: pc_hold_o, ifid_hold_o, pipe_freeze_o = ~mem_ack_i (combinational release); on mem_ack_i=1 -> RUN.
REQ-029 MEM_WAIT cycle counter: cleared on entry, increments each cycle with mem_ack_i=0; when it reaches MEM_TMO-1 with no ack -> ERR.
REQ-030 ERR: holds and freeze at 1, err_o=1; only exit is reset.
REQ-031 start_i=0 in RUN -> IDLE at next edge; in MEM_WAIT it is ignored until ack, then -> IDLE instead of RUN.
REQ-032 Output equations are combinational from state and inputs; no added latency.

Reset
REQ-033 On rst_i=0: state IDLE, wait counter 0, err_o 0, performance counter 0, asynchronously.
REQ-034 Reset asserted mid-MEM_WAIT or in ERR returns to IDLE; pending handshake is abandoned.

Configuration
REQ-035 Macro PIPE_STALL_PERF_EN defined: add output stall_cnt_o [CNT_W-1:0], which increments on every cycle in RUN or MEM_WAIT with pc_hold_o=1, saturates at all-ones, and is cleared only by reset.
REQ-036 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-037 Shared package holds the state encoding constants and the register-index width (5).
REQ-038 One sub-module, hazard_detect: purely combinational load-use compare per REQ-023; the FSM and counters stay in pipe_stall_ctrl.

Verification
REQ-039 Reset, then start_i=1 at cycle 2 -> state_o=1 at cycle 3, pc_hold_o falls to 0.
REQ-040 idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5 -> one cycle of pc_hold_o=1, ifid_hold_o=1, idex_bubble_o=1; idex_rt_i=0 with the same sources -> no stall.
REQ-041 Hazard plus branch_taken_i=1 in the same cycle -> ifid_flush_o=0, idex_bubble_o=1.
REQ-042 mem_req_i=1, ack after 10 cycles -> freeze held for 10 cycles and released in the ack cycle; state returns to 1.
REQ-043 MEM_TMO=16, no ack -> state_o=3 and err_o=1 after 16 cycles; rst_i pulse -> IDLE, err_o=0.
REQ-044 With PIPE_STALL_PERF_EN and CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturated).

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared constants for the pipeline stall controller
//
// Purpose: FSM state encoding and register-index width used by
//          pipe_stall_ctrl and hazard_detect.
// Ports:   none (package).
package pipe_stall_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam int STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_ERR      = 3'd3
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// rtl/pipe_stall_ctrl_hazard_detect.sv - combinational load-use hazard compare
//
// Purpose: flags a load in ID/EX whose destination is read by the
//          instruction in IF/ID. Register 0 never creates a hazard.
// Ports:
//   idex_memread_i  in   ID/EX instruction is a load
//   idex_rt_i       in   load destination register
//   ifid_rs_i       in   IF/ID source register rs
//   ifid_rt_i       in   IF/ID source register rt
//   hazard_o        out  load-use hazard present
module hazard_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rt_i,
  input  logic [REG_IDX_W-1:0] ifid_rs_i,
  input  logic [REG_IDX_W-1:0] ifid_rt_i,
  output logic                 hazard_o
);

  logic w_rt_nonzero;
  logic w_src_match;

  assign w_rt_nonzero = (idex_rt_i != '0);
  assign w_src_match  = (idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i);
  assign hazard_o     = idex_memread_i & w_rt_nonzero & w_src_match;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall / flush / freeze controller
//
// Purpose: sequences IDLE / RUN / MEM_WAIT / ERR and drives the PC, IF/ID
//          and ID/EX control strobes combinationally from state and inputs.
//          A data-cache access that stays unacknowledged for MEM_TMO
//          MEM_WAIT cycles lands in a sticky ERR state left only by reset.
// Optional feature: define PIPE_STALL_PERF_EN to add stall_cnt_o, a
//          saturating count of PC-hold cycles spent in RUN or MEM_WAIT.
// Ports:
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous active-low reset
//   start_i         in   run enable
//   idex_memread_i  in   ID/EX holds a load
//   idex_rt_i       in   load destination register
//   ifid_rs_i       in   IF/ID source register rs
//   ifid_rt_i       in   IF/ID source register rt
//   branch_taken_i  in   branch resolved taken in ID
//   mem_req_i       in   MEM stage has a cache access outstanding
//   mem_ack_i       in   cache completes the access this cycle
//   pc_hold_o       out  PC keeps its value
//   ifid_hold_o     out  IF/ID holds
//   ifid_flush_o    out  IF/ID loads a NOP
//   idex_bubble_o   out  ID/EX loads a NOP
//   pipe_freeze_o   out  ID/EX, EX/MEM, MEM/WB hold
//   err_o           out  sticky memory-timeout error
//   state_o         out  current FSM state
//   stall_cnt_o     out  stall cycle counter (PIPE_STALL_PERF_EN only)
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TMO = 1023,
  parameter int CNT_W   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rt_i,
  input  logic [REG_IDX_W-1:0] ifid_rs_i,
  input  logic [REG_IDX_W-1:0] ifid_rt_i,
  input  logic                 branch_taken_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ack_i,
  output logic                 pc_hold_o,
  output logic                 ifid_hold_o,
  output logic                 ifid_flush_o,
  output logic                 idex_bubble_o,
  output logic                 pipe_freeze_o,
  output logic                 err_o,
  output logic [STATE_W-1:0]   state_o
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt_o
`endif
);

  // The wait counter only ever reaches MEM_TMO-1 before ERR is taken.
  localparam int TMO_W = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

  state_e           r_state;
  logic [TMO_W-1:0] r_wait_cnt;

  logic w_hazard;
  logic w_mem_stall;
  logic w_pc_hold;
  logic w_ifid_hold;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_pipe_freeze;

  hazard_detect u_hazard_detect (
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .hazard_o       (w_hazard)
  );

  assign w_mem_stall = mem_req_i & ~mem_ack_i;

  // Strobes are combinational so a stall or release takes effect in the
  // same cycle the cache request/ack is seen.
  always_comb begin
    w_pc_hold     = 1'b0;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_freeze = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Priority: memory stall, then load-use, then branch flush. The
        // load-use bubble suppresses the flush so the held IF/ID
        // instruction is not discarded.
        if (w_mem_stall) begin
          w_pc_hold     = 1'b1;
          w_ifid_hold   = 1'b1;
          w_pipe_freeze = 1'b1;
        end else if (w_hazard) begin
          w_pc_hold     = 1'b1;
          w_ifid_hold   = 1'b1;
          w_idex_bubble = 1'b1;
        end else if (branch_taken_i) begin
          w_ifid_flush  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        w_pc_hold     = ~mem_ack_i;
        w_ifid_hold   = ~mem_ack_i;
        w_pipe_freeze = ~mem_ack_i;
      end
      default: begin
        // IDLE, ERR and unused encodings keep the whole pipe still.
        w_pc_hold     = 1'b1;
        w_ifid_hold   = 1'b1;
        w_pipe_freeze = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // An outstanding access is seen through to its ack before the
          // run-enable is honoured, so the cache handshake is never dropped.
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= '0;
          end else if (!start_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) begin
            r_state <= start_i ? ST_RUN : ST_IDLE;
          end else if (r_wait_cnt == TMO_LAST) begin
            r_state <= ST_ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + TMO_W'(1);
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_cnt_en;

  assign w_cnt_en = ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT)) && w_pc_hold;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_cnt_en && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

  assign pc_hold_o     = w_pc_hold;
  assign ifid_hold_o   = w_ifid_hold;
  assign ifid_flush_o  = w_ifid_flush;
  assign idex_bubble_o = w_idex_bubble;
  assign pipe_freeze_o = w_pipe_freeze;
  assign err_o         = (r_state == ST_ERR);
  assign state_o       = r_state;

endmodule
